// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder iteration controller: loads one codeword of LLRs, then drives the
// init / row / estimate / column engines until the syndrome clears or the limit hits.
module ldpc_iter_ctrl #(
    parameter int N          = 16,
    parameter int M          = 8,
    parameter int WIDTH      = 8,
    parameter int LOOP_MAX   = 20,
    parameter int ITW        = 7,
    parameter int EARLY_TERM = 1
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 i_val,
    input  logic [WIDTH-1:0]     i_data,
    output logic                 o_rdy,
    input  logic [ITW-1:0]       i_loop_max,
    output logic                 o_lam_wen,
    output logic [$clog2(N)-1:0] o_lam_waddr,
    output logic [WIDTH-1:0]     o_lam_wdata,
    output logic                 o_init_start,
    input  logic                 i_init_done,
    output logic                 o_row_start,
    input  logic                 i_row_done,
    output logic                 o_est_start,
    input  logic                 i_hd_val,
    input  logic                 i_hd_bit,
    input  logic                 i_chk_val,
    input  logic                 i_chk_fail,
    output logic                 o_col_start,
    input  logic                 i_col_done,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [N-1:0]         o_data,
    output logic [ITW-1:0]       o_loop,
    output logic                 o_fail,
    output logic                 o_busy
);
    localparam int AW  = $clog2(N);
    localparam int HCW = $clog2(N + 1);
    localparam int CCW = $clog2(M + 1);

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        INIT = 3'd1,
        ROW  = 3'd2,
        EST  = 3'd3,
        COL  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  ld_cnt_q;
    logic [ITW-1:0] limit_q;
    logic [ITW-1:0] loop_q;
    logic [HCW-1:0] hd_cnt_q;
    logic [CCW-1:0] chk_cnt_q;
    logic           acc_q;
    logic           fail_q;
    logic           val_q;
    logic [N-1:0]   data_q;
    logic           init_start_q;
    logic           row_start_q;
    logic           est_start_q;
    logic           col_start_q;

    logic           load_beat_s;
    logic           hd_take_s;
    logic           chk_take_s;
    logic           est_full_s;
    logic [ITW-1:0] eff_limit_s;

    assign load_beat_s = (state_q == LOAD) && i_val;
    assign hd_take_s   = (state_q == EST) && i_hd_val && (hd_cnt_q < HCW'(N));
    assign chk_take_s  = (state_q == EST) && i_chk_val && (chk_cnt_q < CCW'(M));
    assign est_full_s  = (hd_cnt_q == HCW'(N)) && (chk_cnt_q == CCW'(M));
    // Out-of-range runtime limits (including 0) fall back to the hard ceiling.
    assign eff_limit_s = ((i_loop_max != {ITW{1'b0}}) && (i_loop_max <= ITW'(LOOP_MAX)))
                         ? i_loop_max : ITW'(LOOP_MAX);

    // Controller state, counters, result registers and one-cycle start pulses.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q      <= LOAD;
            ld_cnt_q     <= {AW{1'b0}};
            limit_q      <= {ITW{1'b0}};
            loop_q       <= {ITW{1'b0}};
            hd_cnt_q     <= {HCW{1'b0}};
            chk_cnt_q    <= {CCW{1'b0}};
            acc_q        <= 1'b0;
            fail_q       <= 1'b0;
            val_q        <= 1'b0;
            data_q       <= {N{1'b0}};
            init_start_q <= 1'b0;
            row_start_q  <= 1'b0;
            est_start_q  <= 1'b0;
            col_start_q  <= 1'b0;
        end else begin
            init_start_q <= 1'b0;
            row_start_q  <= 1'b0;
            est_start_q  <= 1'b0;
            col_start_q  <= 1'b0;
            if (hd_take_s) begin
                data_q[hd_cnt_q[AW-1:0]] <= i_hd_bit;
                hd_cnt_q                 <= hd_cnt_q + 1'b1;
            end
            if (chk_take_s) begin
                acc_q     <= acc_q | i_chk_fail;
                chk_cnt_q <= chk_cnt_q + 1'b1;
            end
            case (state_q)
                LOAD: begin
                    if (load_beat_s) begin
                        if (ld_cnt_q == {AW{1'b0}}) begin
                            limit_q <= eff_limit_s;
                        end
                        if (ld_cnt_q == AW'(N - 1)) begin
                            ld_cnt_q     <= {AW{1'b0}};
                            state_q      <= INIT;
                            init_start_q <= 1'b1;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + 1'b1;
                        end
                    end
                end
                INIT: begin
                    if (i_init_done) begin
                        state_q     <= ROW;
                        row_start_q <= 1'b1;
                    end
                end
                ROW: begin
                    if (i_row_done) begin
                        loop_q      <= loop_q + 1'b1;
                        state_q     <= EST;
                        est_start_q <= 1'b1;
                        hd_cnt_q    <= {HCW{1'b0}};
                        chk_cnt_q   <= {CCW{1'b0}};
                        acc_q       <= 1'b0;
                    end
                end
                EST: begin
                    // Decide one cycle after both beat streams are complete.
                    if (est_full_s) begin
                        if ((EARLY_TERM != 0) && !acc_q) begin
                            state_q <= DONE;
                            val_q   <= 1'b1;
                            fail_q  <= 1'b0;
                        end else if (loop_q == limit_q) begin
                            state_q <= DONE;
                            val_q   <= 1'b1;
                            fail_q  <= acc_q;
                        end else begin
                            state_q     <= COL;
                            col_start_q <= 1'b1;
                        end
                    end
                end
                COL: begin
                    if (i_col_done) begin
                        state_q     <= ROW;
                        row_start_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        state_q <= LOAD;
                        val_q   <= 1'b0;
                        loop_q  <= {ITW{1'b0}};
                        fail_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign o_rdy        = (state_q == LOAD);
    assign o_busy       = !((state_q == LOAD) && (ld_cnt_q == {AW{1'b0}}));
    assign o_lam_wen    = load_beat_s;
    assign o_lam_waddr  = ld_cnt_q;
    assign o_lam_wdata  = i_data;
    assign o_init_start = init_start_q;
    assign o_row_start  = row_start_q;
    assign o_est_start  = est_start_q;
    assign o_col_start  = col_start_q;
    assign o_val        = val_q;
    assign o_data       = data_q;
    assign o_loop       = loop_q;
    assign o_fail       = fail_q;

endmodule
